// File: rtl/e_term_pipe_if.sv
// Frame relay / wire turnaround bundle for the east termination tile.
// The slave modport is the tile side; the master modport drives the frame and wire inputs.
interface e_term_pipe_if #(
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int WIRE_COUNT         = 48
);
  logic [FRAME_BITS_PER_ROW-1:0] FrameData;
  logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe;
  logic [FRAME_BITS_PER_ROW-1:0] FrameData_O;
  logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe_O;
  logic [WIRE_COUNT-1:0]         E_in;
  logic [WIRE_COUNT-1:0]         W_out;
  logic [15:0]                   frame_cnt;
  logic                          strobe_err;
  logic                          cfg_busy;

  modport slave (
    input  FrameData, FrameStrobe, E_in,
    output FrameData_O, FrameStrobe_O, W_out, frame_cnt, strobe_err, cfg_busy
  );

  modport master (
    output FrameData, FrameStrobe, E_in,
    input  FrameData_O, FrameStrobe_O, W_out, frame_cnt, strobe_err, cfg_busy
  );
endinterface

// File: rtl/e_term_pipe.sv
// East termination tile: relays configuration frames through an optional register
// pipeline, turns east wires around to the west, and tracks strobe pulses.
module e_term_pipe #(
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int PIPE_STAGES        = 1,
  parameter int WIRE_COUNT         = 48,
  parameter int LOOP_REG           = 1
) (
  input  logic          UserCLK,
  input  logic          Reset,
  output logic          UserCLKo,
  e_term_pipe_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [MAX_FRAMES_PER_COL-1:0] STROBE_ONE = {{(MAX_FRAMES_PER_COL-1){1'b0}}, 1'b1};

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic multi_hot(input logic [MAX_FRAMES_PER_COL-1:0] v);
    return ((v & (v - STROBE_ONE)) != {MAX_FRAMES_PER_COL{1'b0}});
  endfunction

  logic   pipe_nz_s;
  logic   strobe_nz_s;
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic   err_q, err_d;
  logic   busy_q, busy_d;

  assign UserCLKo    = UserCLK;
  assign strobe_nz_s = (bus.FrameStrobe != {MAX_FRAMES_PER_COL{1'b0}});

  generate
    if (PIPE_STAGES > 0) begin : g_pipe
      logic [FRAME_BITS_PER_ROW-1:0] data_q   [PIPE_STAGES];
      logic [MAX_FRAMES_PER_COL-1:0] strobe_q [PIPE_STAGES];
      logic                          nz_s;

      // Data and strobe shift together so they stay cycle-aligned.
      always_ff @(posedge UserCLK) begin
        if (Reset) begin
          for (int i = 0; i < PIPE_STAGES; i++) begin
            data_q[i]   <= '0;
            strobe_q[i] <= '0;
          end
        end else begin
          data_q[0]   <= bus.FrameData;
          strobe_q[0] <= bus.FrameStrobe;
          for (int i = 1; i < PIPE_STAGES; i++) begin
            data_q[i]   <= data_q[i-1];
            strobe_q[i] <= strobe_q[i-1];
          end
        end
      end

      // Any strobe still in flight keeps the tile busy.
      always_comb begin
        nz_s = 1'b0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
          nz_s = nz_s | (|strobe_q[i]);
        end
      end

      assign bus.FrameData_O   = data_q[PIPE_STAGES-1];
      assign bus.FrameStrobe_O = strobe_q[PIPE_STAGES-1];
      assign pipe_nz_s         = nz_s;
    end else begin : g_nopipe
      assign bus.FrameData_O   = bus.FrameData;
      assign bus.FrameStrobe_O = bus.FrameStrobe;
      assign pipe_nz_s         = 1'b0;
    end

    if (LOOP_REG != 0) begin : g_loop_reg
      logic [WIRE_COUNT-1:0] w_q;

      // Registered east-to-west turnaround.
      always_ff @(posedge UserCLK) begin
        if (Reset) begin
          w_q <= '0;
        end else begin
          w_q <= bus.E_in;
        end
      end

      assign bus.W_out = w_q;
    end else begin : g_loop_comb
      assign bus.W_out = bus.E_in;
    end
  endgenerate

  // Pulse FSM on the raw input strobe; counts only IDLE->ACTIVE entries.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe_nz_s) begin
          state_d = ACTIVE;
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (strobe_nz_s) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (multi_hot(bus.FrameStrobe)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    busy_d = (state_d == ACTIVE) | pipe_nz_s;
  end

  // State, counter and status registers.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'h0000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.frame_cnt  = cnt_q;
  assign bus.strobe_err = err_q;
  assign bus.cfg_busy   = busy_q;

endmodule

// File: tb/tb_e_term_pipe.sv
// Bench for e_term_pipe: two configurations share one directed stimulus and are compared
// every cycle with a history-based model; a third instance exercises counter saturation.
module tb_e_term_pipe;
  localparam int FB = 32;
  localparam int FS = 20;
  localparam int WC = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [FB-1:0] fd;
  logic [FS-1:0] fs;
  logic [WC-1:0] ein;
  logic          s_rst;
  logic [FS-1:0] s_fs;
  logic          clko_a, clko_b, clko_s;
  logic          sat_done = 1'b0;
  logic          armed = 1'b0;
  int            errors = 0;
  int            checks = 0;

  e_term_pipe_if #(.FRAME_BITS_PER_ROW(FB), .MAX_FRAMES_PER_COL(FS), .WIRE_COUNT(WC)) if_a ();
  e_term_pipe_if #(.FRAME_BITS_PER_ROW(FB), .MAX_FRAMES_PER_COL(FS), .WIRE_COUNT(WC)) if_b ();
  e_term_pipe_if #(.FRAME_BITS_PER_ROW(FB), .MAX_FRAMES_PER_COL(FS), .WIRE_COUNT(WC)) if_s ();

  assign if_a.FrameData = fd;   assign if_a.FrameStrobe = fs;   assign if_a.E_in = ein;
  assign if_b.FrameData = fd;   assign if_b.FrameStrobe = fs;   assign if_b.E_in = ein;
  assign if_s.FrameData = '0;   assign if_s.FrameStrobe = s_fs; assign if_s.E_in = '0;

  e_term_pipe #(.FRAME_BITS_PER_ROW(FB), .MAX_FRAMES_PER_COL(FS), .PIPE_STAGES(2),
                .WIRE_COUNT(WC), .LOOP_REG(1))
    u_a (.UserCLK(clk), .Reset(rst), .UserCLKo(clko_a), .bus(if_a.slave));
  e_term_pipe #(.FRAME_BITS_PER_ROW(FB), .MAX_FRAMES_PER_COL(FS), .PIPE_STAGES(3),
                .WIRE_COUNT(WC), .LOOP_REG(0))
    u_b (.UserCLK(clk), .Reset(rst), .UserCLKo(clko_b), .bus(if_b.slave));
  e_term_pipe #(.FRAME_BITS_PER_ROW(FB), .MAX_FRAMES_PER_COL(FS), .PIPE_STAGES(1),
                .WIRE_COUNT(WC), .LOOP_REG(1))
    u_s (.UserCLK(clk), .Reset(s_rst), .UserCLKo(clko_s), .bus(if_s.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Input history, index 0 = most recent clock edge.
  logic          h_rst [$];
  logic [FS-1:0] h_fs  [$];
  logic [FB-1:0] h_fd  [$];
  logic [WC-1:0] h_e   [$];
  int unsigned   m_cnt = 0;
  logic          m_err = 1'b0;
  logic          m_prev_nz = 1'b0;

  initial begin : model_rec
    for (int k = 0; k < 8; k++) begin
      h_rst.push_front(1'b1); h_fs.push_front('0); h_fd.push_front('0); h_e.push_front('0);
    end
    forever begin
      @(posedge clk);
      h_rst.push_front(rst); h_fs.push_front(fs); h_fd.push_front(fd); h_e.push_front(ein);
      void'(h_rst.pop_back()); void'(h_fs.pop_back()); void'(h_fd.pop_back()); void'(h_e.pop_back());
      if (rst) begin
        m_cnt = 0; m_err = 1'b0; m_prev_nz = 1'b0; armed = 1'b1;
      end else begin
        if (fs != '0 && !m_prev_nz && m_cnt < 65535) m_cnt++;
        m_prev_nz = (fs != '0);
        if ($countones(fs) > 1) m_err = 1'b1;
      end
    end
  end

  function automatic logic rst_within(input int lo, input int hi);
    for (int j = lo; j <= hi; j++) if (h_rst[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [FS-1:0] exp_fs_o(input int n);
    if (rst_within(0, n-1)) return '0;
    return h_fs[n-1];
  endfunction

  function automatic logic [FB-1:0] exp_fd_o(input int n);
    if (rst_within(0, n-1)) return '0;
    return h_fd[n-1];
  endfunction

  function automatic logic exp_busy(input int n);
    if (h_rst[0]) return 1'b0;
    if (h_fs[0] != '0) return 1'b1;
    for (int j = 0; j < n; j++) if (!rst_within(1, 1+j) && h_fs[1+j] != '0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin : compare
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("a_fd_o",  64'(if_a.FrameData_O),   64'(exp_fd_o(2)));
        chk("a_fs_o",  64'(if_a.FrameStrobe_O), 64'(exp_fs_o(2)));
        chk("a_w_out", 64'(if_a.W_out),         64'(h_rst[0] ? '0 : h_e[0]));
        chk("a_cnt",   64'(if_a.frame_cnt),     64'(m_cnt));
        chk("a_err",   64'(if_a.strobe_err),    64'(m_err));
        chk("a_busy",  64'(if_a.cfg_busy),      64'(exp_busy(2)));
        chk("b_fd_o",  64'(if_b.FrameData_O),   64'(exp_fd_o(3)));
        chk("b_fs_o",  64'(if_b.FrameStrobe_O), 64'(exp_fs_o(3)));
        chk("b_w_out", 64'(if_b.W_out),         64'(ein));
        chk("b_cnt",   64'(if_b.frame_cnt),     64'(m_cnt));
        chk("b_err",   64'(if_b.strobe_err),    64'(m_err));
        chk("b_busy",  64'(if_b.cfg_busy),      64'(exp_busy(3)));
      end
    end
  end

  task automatic cyc(input logic r, input logic [FS-1:0] s, input logic [FB-1:0] d,
                     input logic [WC-1:0] e);
    rst = r; fs = s; fd = d; ein = e;
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [FS-1:0] s;
    logic [FB-1:0] d;
    logic [WC-1:0] e;
  } vec_t;

  vec_t vecs [10];

  initial begin : saturation
    s_rst = 1'b1; s_fs = '0;
    repeat (2) @(posedge clk);
    #2;
    s_rst = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      s_fs = 20'h00001; @(posedge clk); #2;
      s_fs = 20'h00000; @(posedge clk); #2;
      if (i == 0) chk("sat_first", 64'(if_s.frame_cnt), 64'h1);
    end
    chk("sat_fffe", 64'(if_s.frame_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      s_fs = 20'h00001; @(posedge clk); #2;
      s_fs = 20'h00000; @(posedge clk); #2;
    end
    chk("sat_ffff", 64'(if_s.frame_cnt), 64'hFFFF);
    chk("sat_err",  64'(if_s.strobe_err), 64'h0);
    sat_done = 1'b1;
  end

  initial begin : main
    vecs[0] = '{20'h80000, 32'h0123_4567, 48'h0000_0000_0001};
    vecs[1] = '{20'h80000, 32'h89AB_CDEF, 48'h8000_0000_0000};
    vecs[2] = '{20'h00000, 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF};
    vecs[3] = '{20'h00040, 32'h0F0F_0F0F, 48'h1234_5678_9ABC};
    vecs[4] = '{20'h00000, 32'h0000_0000, 48'h0000_0000_0000};
    vecs[5] = '{20'h00400, 32'hA5A5_A5A5, 48'h5A5A_5A5A_5A5A};
    vecs[6] = '{20'h00800, 32'h5A5A_5A5A, 48'hDEAD_BEEF_0000};
    vecs[7] = '{20'hF0000, 32'h1357_9BDF, 48'h0F0F_F0F0_0F0F};
    vecs[8] = '{20'h00000, 32'h2468_ACE0, 48'hFFFF_0000_FFFF};
    vecs[9] = '{20'h00001, 32'h7777_8888, 48'h0000_FFFF_0000};

    cyc(1'b1, '0, '0, '0);
    cyc(1'b1, '0, '0, '0);
    chk("rst_fs_o",  64'(if_a.FrameStrobe_O), 64'h0);
    chk("rst_fd_o",  64'(if_a.FrameData_O),   64'h0);
    chk("rst_cnt",   64'(if_a.frame_cnt),     64'h0);
    chk("rst_busy",  64'(if_a.cfg_busy),      64'h0);
    chk("rst_w_out", 64'(if_a.W_out),         64'h0);
    chk("rst_clko",  64'(clko_a),             64'(clk));

    // Single-cycle frame through a 2-stage pipe.
    cyc(1'b0, 20'h00004, 32'hDEADBEEF, '0);
    chk("p1_cnt",  64'(if_a.frame_cnt), 64'h1);
    chk("p1_busy", 64'(if_a.cfg_busy),  64'h1);
    cyc(1'b0, '0, '0, '0);
    chk("p2_fd_o", 64'(if_a.FrameData_O),   64'hDEADBEEF);
    chk("p2_fs_o", 64'(if_a.FrameStrobe_O), 64'h00004);
    chk("p2_busy", 64'(if_a.cfg_busy),      64'h1);
    cyc(1'b0, '0, '0, '0);
    chk("p3_fs_o", 64'(if_a.FrameStrobe_O), 64'h0);
    chk("p3_busy", 64'(if_a.cfg_busy),      64'h1);
    chk("p3_b_fd", 64'(if_b.FrameData_O),   64'hDEADBEEF);
    cyc(1'b0, '0, '0, '0);
    chk("p4_busy", 64'(if_a.cfg_busy),      64'h0);

    // Held strobe counts once, a new pulse after a gap counts again.
    repeat (5) cyc(1'b0, 20'h00001, 32'h1111_2222, '0);
    cyc(1'b0, 20'h00000, 32'h3333_4444, '0);
    cyc(1'b0, 20'h00002, 32'h5555_6666, '0);
    cyc(1'b0, '0, '0, '0);
    chk("hold_cnt", 64'(if_a.frame_cnt),  64'h3);
    chk("hold_err", 64'(if_a.strobe_err), 64'h0);

    // Wire turnaround: registered vs combinational.
    rst = 1'b0; fs = '0; fd = '0; ein = 48'hA5A5_0000_FFFF;
    #1;
    chk("w_comb_now", 64'(if_b.W_out), 64'hA5A5_0000_FFFF);
    chk("w_reg_prev", 64'(if_a.W_out), 64'h0);
    @(posedge clk);
    #2;
    chk("w_reg_next", 64'(if_a.W_out), 64'hA5A5_0000_FFFF);
    cyc(1'b0, '0, '0, 48'h0123_4567_89AB);

    // Multi-hot strobe flags an error but is relayed unchanged.
    cyc(1'b0, 20'h00003, 32'hCAFE_F00D, '0);
    chk("mh_err1", 64'(if_a.strobe_err), 64'h1);
    cyc(1'b0, 20'h00008, 32'h0000_0008, '0);
    chk("mh_fs_o", 64'(if_a.FrameStrobe_O), 64'h00003);
    chk("mh_err2", 64'(if_a.strobe_err),    64'h1);
    cyc(1'b0, '0, '0, '0);
    chk("mh_err3", 64'(if_a.strobe_err), 64'h1);
    chk("mh_cnt",  64'(if_a.frame_cnt),  64'h4);

    for (int i = 0; i < 10; i++) cyc(1'b0, vecs[i].s, vecs[i].d, vecs[i].e);
    repeat (4) cyc(1'b0, '0, '0, '0);

    // Reset in the middle of a held pulse on the 3-stage pipe.
    cyc(1'b0, 20'h00010, 32'h5555_AAAA, '0);
    cyc(1'b0, 20'h00010, 32'h5555_AAAA, '0);
    cyc(1'b1, 20'h00010, 32'h5555_AAAA, '0);
    cyc(1'b1, 20'h00010, 32'h5555_AAAA, '0);
    chk("r_fs_o", 64'(if_b.FrameStrobe_O), 64'h0);
    chk("r_fd_o", 64'(if_b.FrameData_O),   64'h0);
    chk("r_cnt",  64'(if_b.frame_cnt),     64'h0);
    chk("r_busy", 64'(if_b.cfg_busy),      64'h0);
    chk("r_clko", 64'(clko_b),             64'(clk));
    cyc(1'b0, 20'h00010, 32'h5555_AAAA, '0);
    chk("rr1_fs_o", 64'(if_b.FrameStrobe_O), 64'h0);
    chk("rr1_cnt",  64'(if_b.frame_cnt),     64'h1);
    cyc(1'b0, 20'h00010, 32'h5555_AAAA, '0);
    chk("rr2_fs_o", 64'(if_b.FrameStrobe_O), 64'h0);
    cyc(1'b0, 20'h00010, 32'h5555_AAAA, '0);
    chk("rr3_fs_o", 64'(if_b.FrameStrobe_O), 64'h00010);
    chk("rr3_cnt",  64'(if_b.frame_cnt),     64'h1);
    repeat (5) cyc(1'b0, '0, '0, '0);

    for (int k = 0; k < 200000 && !sat_done; k++) @(posedge clk);
    if (!sat_done) chk("sat_timeout", 64'h0, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e_term_pipe.md
E_TERM_PIPE -- requirements
Module: e_term_pipe

Interface
REQ-001 Parameter FRAME_BITS_PER_ROW, default 32: width of the configuration frame data bus.
REQ-002 Parameter MAX_FRAMES_PER_COL, default 20: width of the frame strobe bus.
REQ-003 Parameter PIPE_STAGES, default 1, legal range 0..4: number of register stages on the frame data and frame strobe path.
REQ-004 Parameter WIRE_COUNT, default 48: number of east-input wires turned around to the west outputs.
REQ-005 Parameter LOOP_REG, default 1: 1 registers the wire turnaround; 0 makes it combinational.
REQ-006 UserCLK  in  1: the single clock; all state is updated on its rising edge.
REQ-007 Reset  in  1: reset, synchronous and active-high.
REQ-008 FrameData  in  FRAME_BITS_PER_ROW: configuration frame data from the neighbouring tile.
REQ-009 FrameStrobe  in  MAX_FRAMES_PER_COL: frame strobes from the neighbouring tile; one-hot or zero.
REQ-010 FrameData_O  out  FRAME_BITS_PER_ROW: relayed frame data.
REQ-011 FrameStrobe_O  out  MAX_FRAMES_PER_COL: relayed frame strobes.
REQ-012 UserCLKo  out  1: UserCLK passed through a clock buffer, with no logic on this path.
REQ-013 E_in  in  WIRE_COUNT: concatenated eastbound wire ends.
REQ-014 W_out  out  WIRE_COUNT: westbound wire beginnings.
REQ-015 frame_cnt  out  16: count of strobe pulses seen.
REQ-016 strobe_err  out  1: sticky flag, set when the strobe bus is not one-hot.
REQ-017 cfg_busy  out  1: high while a strobe pulse is active or the pipeline holds a nonzero strobe.

Function
REQ-018 With PIPE_STAGES = N > 0, FrameData_O and FrameStrobe_O shall equal FrameData and FrameStrobe delayed by exactly N cycles; data and strobe shall stay cycle-aligned.
REQ-019 With PIPE_STAGES = 0, FrameData_O and FrameStrobe_O shall be combinational copies of their inputs, and no pipeline registers shall exist.
REQ-020 With LOOP_REG = 1, W_out[i] shall equal E_in[i] delayed by 1 cycle; with LOOP_REG = 0, W_out shall equal E_in combinationally.
REQ-021 The pulse FSM shall have two states:
- IDLE, with FrameStrobe == 0;
- ACTIVE, with FrameStrobe != 0.
The FSM shall sample the input strobe, not the pipelined strobe.
REQ-022 Transition IDLE->ACTIVE shall occur when FrameStrobe != 0, and shall increment frame_cnt by 1 on that same edge.
REQ-023 Transition ACTIVE->IDLE shall occur when FrameStrobe == 0; with ACTIVE and a nonzero strobe, the FSM shall stay in ACTIVE and shall not increment frame_cnt.
REQ-024 A change of strobe bit while staying nonzero (ACTIVE->ACTIVE) shall not count as a new pulse.
REQ-025 frame_cnt shall saturate at 16'hFFFF and shall not wrap.
REQ-026 strobe_err shall set on any cycle where the population count of FrameStrobe is greater than 1, and shall stay set until Reset.
REQ-027 Strobes with more than one bit set shall still be relayed unchanged; the block shall not filter them.
REQ-028 cfg_busy shall be a registered output, equal to (next state == ACTIVE) OR (any pipeline strobe stage nonzero).

Reset
REQ-029 While Reset = 1 at a clock edge, the following shall be cleared:
- all pipeline stages to 0;
- W_out register to 0;
- FSM to IDLE;
- frame_cnt to 0, strobe_err to 0, cfg_busy to 0.
REQ-030 When PIPE_STAGES > 0, FrameStrobe_O shall be all-zero during Reset and for N cycles after it, so that no spurious frame write reaches downstream tiles.
REQ-031 Reset asserted while in ACTIVE shall return the FSM to IDLE; if the strobe is still nonzero after release, that shall count as a new pulse (+1).
REQ-032 UserCLKo shall be unaffected by Reset.

Verification
REQ-033 PIPE_STAGES = 2: drive FrameData = 32'hDEADBEEF with FrameStrobe = 20'h00004 for 1 cycle -> FrameData_O = 32'hDEADBEEF and FrameStrobe_O = 20'h00004 exactly 2 cycles later; frame_cnt = 1; cfg_busy high for 3 cycles.
REQ-034 Hold FrameStrobe = 20'h00001 for 5 cycles, then drive 0 for 1 cycle, then 20'h00002 for 1 cycle -> frame_cnt = 2; strobe_err = 0.
REQ-035 Drive FrameStrobe = 20'h00003 for 1 cycle, then a valid one-hot strobe -> strobe_err = 1 and stays 1; FrameStrobe_O relays 20'h00003 unchanged.
REQ-036 LOOP_REG = 1: apply E_in = 48'hA5A5_0000_FFFF -> W_out shows that value 1 cycle later; repeat with LOOP_REG = 0 -> W_out shows it in the same cycle.
REQ-037 Preload frame_cnt to 16'hFFFE by issuing pulses, then issue 3 more pulses -> frame_cnt = 16'hFFFF.
REQ-038 Assert Reset mid-pulse with the strobe held at 20'h00010 and PIPE_STAGES = 3 -> outputs are 0 during Reset; FrameStrobe_O = 0 for 3 cycles after release; frame_cnt = 1 after release.
